// File: rtl/mux_bus_arbiter.sv
// Round-robin arbiter for two requesters sharing one registered output word.
// Grants are combinational; OUT/IR_CU/OUT_VALID/XFER_COUNT are registered.
module mux_bus_arbiter #(
  parameter int WIDTH   = 32,
  parameter int COUNT_W = 16
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               REQ1,
  input  logic [WIDTH-1:0]   IN1,
  output logic               GNT1,
  input  logic               REQ2,
  input  logic [WIDTH-1:0]   IN2,
  output logic               GNT2,
  output logic               IR_CU,
  output logic [WIDTH-1:0]   OUT,
  output logic               OUT_VALID,
  input  logic               OUT_READY,
  output logic [COUNT_W-1:0] XFER_COUNT
);

  typedef enum logic {EMPTY, FULL} state_t;

  typedef struct packed {
    logic             req;
    logic [WIDTH-1:0] data;
  } req_t;

  state_t state;
  logic   last;
  logic   slot_free;
  logic   xfer;
  req_t   rq1, rq2;

  assign rq1 = '{req: REQ1, data: IN1};
  assign rq2 = '{req: REQ2, data: IN2};

  assign OUT_VALID = (state == FULL);
  assign slot_free = !RST && ((state == EMPTY) || OUT_READY);
  assign xfer      = (state == FULL) && OUT_READY;

  // On a tie the side that did not win last time goes next; last=1 favours IN1.
  always_comb begin
    GNT1 = 1'b0;
    GNT2 = 1'b0;
    if (slot_free) begin
      GNT1 = rq1.req && (!rq2.req || last);
      GNT2 = rq2.req && (!rq1.req || !last);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= EMPTY;
      OUT        <= '0;
      IR_CU      <= 1'b0;
      last       <= 1'b1;
      XFER_COUNT <= '0;
    end else begin
      if (GNT1 || GNT2) begin
        OUT   <= GNT2 ? rq2.data : rq1.data;
        IR_CU <= GNT2;
        last  <= GNT2;
        state <= FULL;
      end else if (xfer) begin
        state <= EMPTY;
      end
      if (xfer) XFER_COUNT <= XFER_COUNT + 1'b1;
    end
  end

endmodule
